fp_normalize: RTL and testbench

FP_NORMALIZE -- requirements
Module: fp_normalize

---
 rtl/fp_normalize.sv | 138 +++++++++++++
 tb/tb_fp_normalize.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize.sv
// Post add/sub normalizer: shifts the mantissa magnitude into hidden-bit form,
// adjusts the exponent and packs an IEEE-754 single with overflow/underflow flags.
module fp_normalize (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] mag_in,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf,
    output logic [1:0]  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid is high only in OUT, and the
    // packed result is held stable until out_ready is seen.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [24:0] mag_q, mag_d;
    logic [8:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic [8:0]  exp_inc;
    logic [8:0]  exp_dec;
    logic [7:0]  exp_norm;

    assign exp_inc  = exp_q + 9'd1;
    assign exp_dec  = exp_q - 9'd1;
    assign exp_norm = (exp_q == 9'd0) ? 8'd1 : exp_q[7:0];

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        done_d   = done_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_d   = mag_in;
                    exp_d   = {1'b0, exp_in};
                    sign_d  = sign_in;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = NORM;
                end
            end
            NORM: begin
                // The packed word is registered one cycle before OUT is entered.
                if (done_q) begin
                    state_d = OUT;
                end else if (exp_q == 9'd255) begin
                    result_d = {sign_q, 8'hFF, 23'h0};
                    ovf_d    = 1'b1;
                    done_d   = 1'b1;
                end else if (mag_q == 25'd0) begin
                    result_d = 32'h0;
                    done_d   = 1'b1;
                end else if (mag_q[24]) begin
                    if (exp_inc >= 9'd255) begin
                        result_d = {sign_q, 8'hFF, 23'h0};
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_inc[7:0], mag_q[23:1]};
                    end
                    done_d = 1'b1;
                end else if (mag_q[23]) begin
                    result_d = {sign_q, exp_norm, mag_q[22:0]};
                    done_d   = 1'b1;
                end else if (exp_q <= 9'd1) begin
                    result_d = {sign_q, 8'h00, mag_q[22:0]};
                    unf_d    = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    mag_d = {mag_q[23:0], 1'b0};
                    exp_d = exp_dec;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mag_q    <= 25'd0;
            exp_q    <= 9'd0;
            sign_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'h0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Randomized bench for fp_normalize, checked against an arithmetic reference
// model of the normalization rules through an expected-value queue.
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] mag_in = 25'd0;
    logic        sign_in = 1'b0;
    logic [7:0]  exp_in = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [33:0] exp_q[$];
    int          lat_q[$];

    fp_normalize dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mag_in    (mag_in),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: closed-form normalization (leading-one position, clamped shift count).
    task automatic ref_model(input logic [24:0] m, input logic s, input logic [7:0] e,
                             output logic [31:0] r, output logic o, output logic u,
                             output int k);
        int     p;
        int     ee;
        int     sh;
        int     mi;
        longint mm;
        o = 1'b0;
        u = 1'b0;
        k = 0;
        r = 32'h0;
        if (e == 8'hFF) begin
            r = {s, 8'hFF, 23'h0};
            o = 1'b1;
        end else if (m == 25'd0) begin
            r = 32'h0;
        end else if (m >= 25'h1000000) begin
            ee = int'(e) + 1;
            if (ee >= 255) begin
                r = {s, 8'hFF, 23'h0};
                o = 1'b1;
            end else begin
                r = {s, ee[7:0], m[23:1]};
            end
        end else begin
            mi = int'(m);
            p  = $clog2(mi + 1) - 1;
            ee = int'(e);
            sh = 23 - p;
            if (ee <= 1) sh = 0;
            else if (sh > ee - 1) sh = ee - 1;
            k  = sh;
            mm = longint'(mi) << sh;
            ee = ee - sh;
            if (mm >= 64'h800000) begin
                if (ee == 0) ee = 1;
                r = {s, ee[7:0], mm[22:0]};
            end else begin
                r = {s, 8'h00, mm[22:0]};
                u = 1'b1;
            end
        end
    endtask

    // driver: one full transaction with 'hold' cycles of out_ready backpressure
    task automatic run_tx(input logic [24:0] m, input logic s, input logic [7:0] e, input int hold);
        logic [31:0] r;
        logic        o;
        logic        u;
        int          k;
        int          w;
        int          cycles;
        logic [33:0] expv;
        int          lat;

        ref_model(m, s, e, r, o, u, k);
        exp_q.push_back({o, u, r});
        lat_q.push_back(2 + k);

        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check_val("in_ready_timeout", 64'd0, 64'd1);

        @(negedge clk);
        mag_in   = m;
        sign_in  = s;
        exp_in   = e;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        mag_in   = 25'($urandom);
        exp_in   = 8'($urandom);

        cycles = 0;
        while (!out_valid && cycles < 60) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end

        expv = exp_q.pop_front();
        lat  = lat_q.pop_front();
        if (!out_valid) begin
            check_val("out_valid_timeout", 64'd0, 64'd1);
            return;
        end
        check_val("latency", 64'(cycles), 64'(lat));
        check_val("result", 64'(result), 64'(expv[31:0]));
        check_val("ovf", 64'(ovf), 64'(expv[33]));
        check_val("unf", 64'(unf), 64'(expv[32]));

        for (int i = 0; i < hold; i++) begin
            // upstream tries to push while busy; must be ignored
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_val("hold_result", 64'(result), 64'(expv[31:0]));
            check_val("hold_in_ready", 64'(in_ready), 64'd0);
            check_val("hold_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("post_out_valid", 64'(out_valid), 64'd0);
        check_val("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [24:0] m;
        logic [7:0]  e;

        // reset state
        repeat (2) @(negedge clk);
        check_val("rst_result", 64'(result), 64'h0);
        check_val("rst_ovf", 64'(ovf), 64'd0);
        check_val("rst_unf", 64'(unf), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // directed corner cases
        run_tx(25'h0800000, 1'b0, 8'h7F, 0);
        run_tx(25'h1000000, 1'b1, 8'h7F, 1);
        run_tx(25'h1000000, 1'b0, 8'hFE, 0);
        run_tx(25'h0000001, 1'b0, 8'h7F, 0);
        run_tx(25'h0400000, 1'b0, 8'h01, 0);
        run_tx(25'h0000000, 1'b1, 8'h55, 0);
        run_tx(25'h0123456, 1'b1, 8'hFF, 0);
        run_tx(25'h0000010, 1'b0, 8'h05, 0);
        run_tx(25'h0800001, 1'b1, 8'h00, 0);
        run_tx(25'h0ABCDEF, 1'b0, 8'h40, 5);

        // reset pulse while in NORM discards the transaction at once
        @(negedge clk);
        mag_in   = 25'h0000001;
        exp_in   = 8'h7F;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        check_val("midrst_in_ready", 64'(in_ready), 64'd1);
        check_val("midrst_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_tx(25'h1FFFFFF, 1'b1, 8'h80, 2);

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 4))
                0: m = 25'($urandom);
                1: m = 25'($urandom_range(1, 255));
                2: m = 25'd0;
                3: m = 25'($urandom) | 25'h1000000;
                default: m = 25'($urandom) >> $urandom_range(1, 24);
            endcase
            case ($urandom_range(0, 3))
                0: e = 8'($urandom_range(0, 2));
                1: e = 8'($urandom_range(253, 255));
                default: e = 8'($urandom);
            endcase
            run_tx(m, 1'($urandom), e, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
